// File: rtl/fpalu_operand_issue.sv
// fpalu_operand_issue: operand-issue stage in front of the single-precision FP
// multiplier. Operand pairs are buffered in a DEPTH-entry FIFO, classified on
// their way into an output register, and handed to the multiplier through a
// second valid/ready handshake so its datapath only ever sees registered operands.
// Optional build macro: FP_OPERAND_STATS_EN adds issue/special-case counters.
module fpalu_operand_issue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_a,
  input  logic [31:0]       in_b,
  output logic              mul_valid,
  input  logic              mul_ready,
  output logic [32:0]       mul_a,
  output logic [32:0]       mul_b,
  output logic [1:0]        op_class,
  output logic [PTR_W:0]    fifo_count
`ifdef FP_OPERAND_STATS_EN
  ,
  output logic [15:0]       stat_issued,
  output logic [15:0]       stat_special
`endif
);

  localparam logic [PTR_W:0] FULL_C = (PTR_W+1)'(DEPTH);

  typedef enum logic {ST_EMPTY = 1'b0, ST_HOLD = 1'b1} out_state_e;

  // Pair classification: NaN beats inf beats zero beats normal; inf*0 is NaN.
  function automatic logic [1:0] classify(input logic [31:0] a, input logic [31:0] b);
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      return 2'b11;
    end else if (a_inf || b_inf) begin
      return 2'b10;
    end else if (a_zero || b_zero) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  logic [31:0]      mem_a_q [DEPTH];
  logic [31:0]      mem_b_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  out_state_e       state_q;
  logic [31:0]      out_a_q;
  logic [31:0]      out_b_q;
  logic [1:0]       cls_q;
  logic             push_s;
  logic             pop_s;

  // in_ready never looks at a pop: a full FIFO refuses even if it drains this cycle.
  assign in_ready = (count_q != FULL_C) && !flush;
  assign push_s   = in_valid && in_ready;
  // The output register pulls a new entry when it is empty or being consumed.
  assign pop_s    = (count_q != '0) && ((state_q == ST_EMPTY) || mul_ready);

  assign mul_valid  = (state_q == ST_HOLD);
  assign mul_a      = {1'b0, out_a_q};
  assign mul_b      = {1'b0, out_b_q};
  assign op_class   = cls_q;
  assign fifo_count = count_q;

  // Occupancy update; simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_a_q[wr_ptr_q] <= in_a;
      mem_b_q[wr_ptr_q] <= in_b;
    end
  end

  // Pointers, occupancy and the EMPTY/HOLD output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_EMPTY;
      out_a_q  <= 32'd0;
      out_b_q  <= 32'd0;
      cls_q    <= 2'b00;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_EMPTY;
      out_a_q  <= 32'd0;
      out_b_q  <= 32'd0;
      cls_q    <= 2'b00;
    end else begin
      count_q <= count_d;
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        out_a_q  <= mem_a_q[rd_ptr_q];
        out_b_q  <= mem_b_q[rd_ptr_q];
        cls_q    <= classify(mem_a_q[rd_ptr_q], mem_b_q[rd_ptr_q]);
      end
      case (state_q)
        ST_EMPTY: state_q <= pop_s ? ST_HOLD : ST_EMPTY;
        ST_HOLD:  state_q <= (mul_ready && !pop_s) ? ST_EMPTY : ST_HOLD;
        default:  state_q <= ST_EMPTY;
      endcase
    end
  end

`ifdef FP_OPERAND_STATS_EN
  logic [15:0] issued_q;
  logic [15:0] special_q;
  logic        fire_s;

  assign fire_s       = mul_valid && mul_ready;
  assign stat_issued  = issued_q;
  assign stat_special = special_q;

  // Saturating counters of issued pairs and of issued special-case pairs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_q  <= 16'd0;
      special_q <= 16'd0;
    end else if (flush) begin
      issued_q  <= 16'd0;
      special_q <= 16'd0;
    end else if (fire_s) begin
      if (issued_q != 16'hFFFF) begin
        issued_q <= issued_q + 16'd1;
      end
      if ((cls_q != 2'b00) && (special_q != 16'hFFFF)) begin
        special_q <= special_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fpalu_operand_issue.sv
// Directed bench for fpalu_operand_issue with a queue scoreboard: each accepted
// pair is queued with its expected class and checked when the DUT issues it.
module tb_fpalu_operand_issue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        mul_valid;
  logic        mul_ready;
  logic [32:0] mul_a;
  logic [32:0] mul_b;
  logic [1:0]  op_class;
  logic [2:0]  fifo_count;
`ifdef FP_OPERAND_STATS_EN
  logic [15:0] stat_issued;
  logic [15:0] stat_special;
`endif

  fpalu_operand_issue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .mul_valid  (mul_valid),
    .mul_ready  (mul_ready),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .op_class   (op_class),
    .fifo_count (fifo_count)
`ifdef FP_OPERAND_STATS_EN
    ,
    .stat_issued  (stat_issued),
    .stat_special (stat_special)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [1:0]  drv_cls;
  logic [65:0] sb[$];
  logic [65:0] exp_e;

  // Independent reference classifier for the pseudo-random traffic.
  function automatic logic [1:0] ref_class(input logic [31:0] a, input logic [31:0] b);
    logic [1:0] ca, cb;
    ca = (a[30:23] == 8'hFF) ? ((a[22:0] != 23'd0) ? 2'b11 : 2'b10) : ((a[30:23] == 8'h00) ? 2'b01 : 2'b00);
    cb = (b[30:23] == 8'hFF) ? ((b[22:0] != 23'd0) ? 2'b11 : 2'b10) : ((b[30:23] == 8'h00) ? 2'b01 : 2'b00);
    if (ca == 2'b11 || cb == 2'b11) return 2'b11;
    if ((ca == 2'b10 && cb == 2'b01) || (ca == 2'b01 && cb == 2'b10)) return 2'b11;
    if (ca == 2'b10 || cb == 2'b10) return 2'b10;
    if (ca == 2'b01 || cb == 2'b01) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] cls);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    drv_cls  = cls;
  endtask

  // One clock: scoreboard sampling at the falling edge, then return just after the rising edge.
  task automatic step();
    @(negedge clk);
    if (flush) begin
      sb.delete();
    end else begin
      if (mul_valid && mul_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $error("FAIL sb_underflow observed=%0h expected=none", {mul_a, mul_b, op_class});
        end else begin
          exp_e = sb.pop_front();
          n_cmp--;
          chk("sb_pair", 72'({mul_a, mul_b, op_class}),
              72'({1'b0, exp_e[65:34], 1'b0, exp_e[33:2], exp_e[1:0]}));
        end
      end
      if (in_valid && in_ready) sb.push_back({in_a, in_b, drv_cls});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0;
    mul_ready = 1'b0; drv_cls = 2'b00;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_mul_valid", 72'(mul_valid), 72'd0);
    chk("rst_mul_a", 72'(mul_a), 72'd0);
    chk("rst_mul_b", 72'(mul_b), 72'd0);
    chk("rst_op_class", 72'(op_class), 72'd0);
    chk("rst_fifo_count", 72'(fifo_count), 72'd0);
    chk("rst_in_ready", 72'(in_ready), 72'd1);
    rst = 1'b0;

    // Single pair: visible one edge after the push edge.
    mul_ready = 1'b1;
    drive(32'h3F800000, 32'h40000000, 2'b00);
    step();
    in_valid = 1'b0;
    chk("lat_count_n", 72'(fifo_count), 72'd1);
    chk("lat_valid_n", 72'(mul_valid), 72'd0);
    step();
    chk("lat_valid_n1", 72'(mul_valid), 72'd1);
    chk("lat_mul_a", 72'(mul_a), 72'h0_3F800000);
    chk("lat_mul_b", 72'(mul_b), 72'h0_40000000);
    chk("lat_class", 72'(op_class), 72'd0);
    step(); step();

    // Special-case classes in order.
    drive(32'h00000000, 32'h7F800000, 2'b11); step();
    drive(32'h7F800000, 32'h40000000, 2'b10); step();
    drive(32'h80000000, 32'h3F800000, 2'b01); step();
    drive(32'h7FC00000, 32'h3F800000, 2'b11); step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("cls_drained", 72'(mul_valid), 72'd0);

    // Capacity with the consumer stalled: DEPTH+1 accepted.
    mul_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(32'h3F800000 + 32'(i), 32'h40400000 + 32'(i), 2'b00);
      chk($sformatf("cap_in_ready_%0d", i), 72'(in_ready), (i < 5) ? 72'd1 : 72'd0);
      step();
    end
    in_valid = 1'b0;
    chk("cap_count", 72'(fifo_count), 72'd4);
    chk("cap_in_ready_after", 72'(in_ready), 72'd0);
    chk("cap_valid", 72'(mul_valid), 72'd1);
    mul_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("drain_valid_%0d", i), 72'(mul_valid), 72'd1);
      step();
    end
    chk("drain_done", 72'(mul_valid), 72'd0);
    chk("drain_sb_left", 72'(sb.size()), 72'd0);

    // Sustained streaming with pointer wrap.
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) a[30:23] = 8'hFF;
      if (i % 5 == 2) b[30:23] = 8'h00;
      drive(a, b, ref_class(a, b));
      step();
      if (i > 0) begin
        chk($sformatf("stream_count_%0d", i), 72'(fifo_count), 72'd1);
        chk($sformatf("stream_valid_%0d", i), 72'(mul_valid), 72'd1);
      end
    end
    in_valid = 1'b0;
    step(); step(); step();
    chk("stream_sb_left", 72'(sb.size()), 72'd0);
    chk("stream_idle", 72'(mul_valid), 72'd0);

    // Asynchronous reset mid-cycle with pairs held.
    mul_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h41000000 + 32'(i), 32'h41100000, 2'b00);
      step();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 72'(mul_valid), 72'd0);
    chk("arst_count", 72'(fifo_count), 72'd0);
    rst = 1'b0;
    sb.delete();

    // Flush with a simultaneous push: everything cleared, offered pair dropped.
    for (int i = 0; i < 3; i++) begin
      drive(32'h42000000 + 32'(i), 32'h42100000, 2'b00);
      step();
    end
    drive(32'h43000000, 32'h43100000, 2'b00);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 72'(in_ready), 72'd0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 72'(mul_valid), 72'd0);
    chk("flush_count", 72'(fifo_count), 72'd0);
    chk("flush_mul_a", 72'(mul_a), 72'd0);
    mul_ready = 1'b1;
    step(); step();
    chk("flush_dropped_valid", 72'(mul_valid), 72'd0);
    chk("flush_dropped_count", 72'(fifo_count), 72'd0);

`ifdef FP_OPERAND_STATS_EN
    chk("stat_issued_clr", 72'(stat_issued), 72'd0);
    chk("stat_special_clr", 72'(stat_special), 72'd0);
    for (int i = 0; i < 10; i++) begin
      if (i == 2 || i == 5 || i == 8) drive(32'h3F800000, 32'h7F800000, 2'b10);
      else drive(32'h3F800000 + 32'(i), 32'h40000000, 2'b00);
      step();
    end
    in_valid = 1'b0;
    step(); step(); step();
    chk("stat_issued", 72'(stat_issued), 72'd10);
    chk("stat_special", 72'(stat_special), 72'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
